// File: rtl/mem_stage_sb.sv
// MEM pipeline stage with sub-word load/store formatting, misalignment detection
// and a posted store buffer that drains ahead of loads over a req/ack memory port.
module mem_stage_sb #(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned SB_DEPTH   = 4,
    parameter int unsigned REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [REG_ADDR_W-1:0] wd_i,
    input  logic                  wreg_i,
    input  logic [31:0]           wdata_i,
    input  logic [3:0]            op_i,
    input  logic [ADDR_W-1:0]     mem_addr_i,
    input  logic [31:0]           reg2_i,
    input  logic                  mem_ack_i,
    input  logic [31:0]           mem_data_i,
    output logic [REG_ADDR_W-1:0] wd_o,
    output logic                  wreg_o,
    output logic [31:0]           wdata_o,
    output logic                  misalign_o,
    output logic                  stallreq,
    output logic                  mem_req_o,
    output logic                  mem_we_o,
    output logic [ADDR_W-1:0]     mem_addr_o,
    output logic [3:0]            mem_sel_o,
    output logic [31:0]           mem_data_o
);

    localparam int unsigned PtrW = $clog2(SB_DEPTH);
    localparam int unsigned CntW = PtrW + 1;
    localparam logic [CntW-1:0] CntFull = CntW'(SB_DEPTH);

    localparam logic [3:0] OpLb  = 4'd1;
    localparam logic [3:0] OpLbu = 4'd2;
    localparam logic [3:0] OpLh  = 4'd3;
    localparam logic [3:0] OpLhu = 4'd4;
    localparam logic [3:0] OpLw  = 4'd5;
    localparam logic [3:0] OpSb  = 4'd6;
    localparam logic [3:0] OpSh  = 4'd7;
    localparam logic [3:0] OpSw  = 4'd8;

    typedef enum logic [1:0] {StIdle, StDrain, StLoad, StDone} state_e;

    state_e state_q, state_d;

    logic [1:0]  off;
    logic        is_load, is_store, misalign, load_ok, store_ok;
    logic [3:0]  st_sel;
    logic [31:0] st_data;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_ext;

    // Store buffer storage and bookkeeping
    logic [ADDR_W-3:0] sb_waddr_q [SB_DEPTH];
    logic [3:0]        sb_sel_q   [SB_DEPTH];
    logic [31:0]       sb_data_q  [SB_DEPTH];
    logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              sb_full, sb_empty, push, pop;

    // Registered memory-side outputs and captured load word
    logic              req_q, req_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [3:0]        sel_q, sel_d;
    logic [31:0]       data_q, data_d;
    logic [31:0]       ld_data_q, ld_data_d;

    assign off = mem_addr_i[1:0];

    // Decode the memory op and flag misaligned halfword/word accesses
    always_comb begin
        is_load  = 1'b0;
        is_store = 1'b0;
        misalign = 1'b0;
        case (op_i)
            OpLb, OpLbu: is_load = 1'b1;
            OpLh, OpLhu: begin is_load = 1'b1;  misalign = off[0]; end
            OpLw:        begin is_load = 1'b1;  misalign = |off;   end
            OpSb:        is_store = 1'b1;
            OpSh:        begin is_store = 1'b1; misalign = off[0]; end
            OpSw:        begin is_store = 1'b1; misalign = |off;   end
            default:     ;
        endcase
    end

    assign load_ok  = is_load & ~misalign;
    assign store_ok = is_store & ~misalign;

    // Format store lanes: narrow data is replicated across the word
    always_comb begin
        st_sel  = 4'b1111;
        st_data = reg2_i;
        case (op_i)
            OpSb: begin
                st_sel  = 4'b0001 << off;
                st_data = {4{reg2_i[7:0]}};
            end
            OpSh: begin
                st_sel  = off[1] ? 4'b1100 : 4'b0011;
                st_data = {2{reg2_i[15:0]}};
            end
            default: ;
        endcase
    end

    assign sb_full  = (cnt_q == CntFull);
    assign sb_empty = (cnt_q == '0);
    assign push     = store_ok & ~sb_full & ~rst;
    assign pop      = (state_q == StDrain) & mem_ack_i;

    // Occupancy: simultaneous push and pop leaves the count unchanged
    always_comb begin
        cnt_d = cnt_q;
        if (push && !pop) begin
            cnt_d = cnt_q + CntW'(1);
        end else if (!push && pop) begin
            cnt_d = cnt_q - CntW'(1);
        end
    end

    // Next-state: drain has priority over loads
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (!sb_empty) begin
                    state_d = StDrain;
                end else if (load_ok) begin
                    state_d = StLoad;
                end
            end
            StDrain: if (mem_ack_i) state_d = StIdle;
            StLoad:  if (mem_ack_i) state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Next values of the registered memory interface; held until ack
    always_comb begin
        req_d     = req_q;
        we_d      = we_q;
        addr_d    = addr_q;
        sel_d     = sel_q;
        data_d    = data_q;
        ld_data_d = ld_data_q;
        unique case (state_q)
            StIdle: begin
                if (!sb_empty) begin
                    req_d  = 1'b1;
                    we_d   = 1'b1;
                    addr_d = {sb_waddr_q[rd_ptr_q], 2'b00};
                    sel_d  = sb_sel_q[rd_ptr_q];
                    data_d = sb_data_q[rd_ptr_q];
                end else if (load_ok) begin
                    req_d  = 1'b1;
                    we_d   = 1'b0;
                    addr_d = {mem_addr_i[ADDR_W-1:2], 2'b00};
                    sel_d  = 4'b1111;
                    data_d = '0;
                end
            end
            StDrain, StLoad: begin
                if (mem_ack_i) begin
                    req_d  = 1'b0;
                    we_d   = 1'b0;
                    addr_d = '0;
                    sel_d  = '0;
                    data_d = '0;
                    if (state_q == StLoad) begin
                        ld_data_d = mem_data_i;
                    end
                end
            end
            default: ;
        endcase
    end

    // State, occupancy and memory-interface registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            req_q     <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            sel_q     <= '0;
            data_q    <= '0;
            ld_data_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
            req_q     <= req_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            sel_q     <= sel_d;
            data_q    <= data_d;
            ld_data_q <= ld_data_d;
        end
    end

    // Store buffer payload; contents are meaningless once the count is cleared
    always_ff @(posedge clk) begin
        if (push) begin
            sb_waddr_q[wr_ptr_q] <= mem_addr_i[ADDR_W-1:2];
            sb_sel_q[wr_ptr_q]   <= st_sel;
            sb_data_q[wr_ptr_q]  <= st_data;
        end
    end

    // Extract and extend the captured load word by op and byte offset
    always_comb begin
        case (off)
            2'd0:    ld_byte = ld_data_q[7:0];
            2'd1:    ld_byte = ld_data_q[15:8];
            2'd2:    ld_byte = ld_data_q[23:16];
            default: ld_byte = ld_data_q[31:24];
        endcase
        ld_half = off[1] ? ld_data_q[31:16] : ld_data_q[15:0];
        case (op_i)
            OpLb:    ld_ext = {{24{ld_byte[7]}}, ld_byte};
            OpLbu:   ld_ext = {24'd0, ld_byte};
            OpLh:    ld_ext = {{16{ld_half[15]}}, ld_half};
            OpLhu:   ld_ext = {16'd0, ld_half};
            default: ld_ext = ld_data_q;
        endcase
    end

    // Writeback passthrough with load-result and misalignment overrides
    always_comb begin
        wd_o       = rst ? '0 : wd_i;
        wreg_o     = ~rst & wreg_i & ~misalign;
        misalign_o = ~rst & misalign;
        stallreq   = ~rst & ((store_ok & sb_full) | (load_ok & (state_q != StDone)));
        if (rst) begin
            wdata_o = '0;
        end else if (load_ok && state_q == StDone) begin
            wdata_o = ld_ext;
        end else begin
            wdata_o = wdata_i;
        end
    end

    assign mem_req_o  = req_q;
    assign mem_we_o   = we_q;
    assign mem_addr_o = addr_q;
    assign mem_sel_o  = sel_q;
    assign mem_data_o = data_q;

endmodule

// File: tb/tb_mem_stage_sb.sv
// Bench for mem_stage_sb: directed scenarios plus random instruction stream,
// checked against a byte-addressed memory model and an expected-write queue.
module tb_mem_stage_sb;

    localparam int unsigned AW    = 32;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned RW    = 5;

    localparam logic [3:0] OpNone = 4'd0;
    localparam logic [3:0] OpLb   = 4'd1;
    localparam logic [3:0] OpLbu  = 4'd2;
    localparam logic [3:0] OpLh   = 4'd3;
    localparam logic [3:0] OpLhu  = 4'd4;
    localparam logic [3:0] OpLw   = 4'd5;
    localparam logic [3:0] OpSb   = 4'd6;
    localparam logic [3:0] OpSh   = 4'd7;
    localparam logic [3:0] OpSw   = 4'd8;

    logic          clk = 1'b0;
    logic          rst;
    logic [RW-1:0] wd_i;
    logic          wreg_i;
    logic [31:0]   wdata_i;
    logic [3:0]    op_i;
    logic [AW-1:0] mem_addr_i;
    logic [31:0]   reg2_i;
    logic          mem_ack_i;
    logic [31:0]   mem_data_i;
    logic [RW-1:0] wd_o;
    logic          wreg_o;
    logic [31:0]   wdata_o;
    logic          misalign_o;
    logic          stallreq;
    logic          mem_req_o;
    logic          mem_we_o;
    logic [AW-1:0] mem_addr_o;
    logic [3:0]    mem_sel_o;
    logic [31:0]   mem_data_o;

    mem_stage_sb #(
        .ADDR_W     (AW),
        .SB_DEPTH   (DEPTH),
        .REG_ADDR_W (RW)
    ) u_dut (
        .clk        (clk),
        .rst        (rst),
        .wd_i       (wd_i),
        .wreg_i     (wreg_i),
        .wdata_i    (wdata_i),
        .op_i       (op_i),
        .mem_addr_i (mem_addr_i),
        .reg2_i     (reg2_i),
        .mem_ack_i  (mem_ack_i),
        .mem_data_i (mem_data_i),
        .wd_o       (wd_o),
        .wreg_o     (wreg_o),
        .wdata_o    (wdata_o),
        .misalign_o (misalign_o),
        .stallreq   (stallreq),
        .mem_req_o  (mem_req_o),
        .mem_we_o   (mem_we_o),
        .mem_addr_o (mem_addr_o),
        .mem_sel_o  (mem_sel_o),
        .mem_data_o (mem_data_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] addr;
        logic [3:0]  sel;
        logic [31:0] data;
    } wr_t;

    int          n_total = 0;
    int          n_bad   = 0;
    wr_t         exp_wr[$];
    logic [7:0]  ref_mem  [logic [31:0]];
    logic [7:0]  ref_snap [logic [31:0]];
    logic [7:0]  rsp_mem  [logic [31:0]];
    bit          hold_ack   = 1'b0;
    bit          force_ack  = 1'b0;
    int          max_wait   = 0;
    int          release_at = 1000000;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] init_byte(input logic [31:0] a);
        return a[7:0] ^ 8'h3c ^ {a[3:0], a[7:4]};
    endfunction

    function automatic logic [7:0] rd_ref(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : init_byte(a);
    endfunction

    function automatic logic [7:0] rd_rsp(input logic [31:0] a);
        return rsp_mem.exists(a) ? rsp_mem[a] : init_byte(a);
    endfunction

    function automatic int op_size(input logic [3:0] op);
        case (op)
            OpLb, OpLbu, OpSb: return 1;
            OpLh, OpLhu, OpSh: return 2;
            OpLw, OpSw:        return 4;
            default:           return 0;
        endcase
    endfunction

    // Memory responder: random ack latency, applies writes, serves reads
    initial begin
        int          wait_cnt = 0;
        bit          in_req   = 1'b0;
        logic [68:0] snap     = '0;
        logic [68:0] cur;
        wr_t         e;
        mem_ack_i  = 1'b0;
        mem_data_i = '0;
        forever begin
            @(negedge clk);
            mem_ack_i  = force_ack;
            mem_data_i = '0;
            cur = {mem_we_o, mem_addr_o, mem_sel_o, mem_data_o};
            if (rst) begin
                wait_cnt = 0;
                in_req   = 1'b0;
            end else if (mem_req_o) begin
                if (!in_req) begin
                    in_req = 1'b1;
                    snap   = cur;
                end
                if (!hold_ack) begin
                    if (wait_cnt == 0) begin
                        check_eq("req_stable", 32'(cur == snap), 32'd1);
                        mem_ack_i = 1'b1;
                        in_req    = 1'b0;
                        wait_cnt  = $urandom_range(0, max_wait);
                        if (mem_we_o) begin
                            check_eq("write_expected", 32'(exp_wr.size() != 0), 32'd1);
                            if (exp_wr.size() != 0) begin
                                e = exp_wr.pop_front();
                                check_eq("wr_addr", mem_addr_o, e.addr);
                                check_eq("wr_sel", 32'(mem_sel_o), 32'(e.sel));
                                check_eq("wr_data", mem_data_o, e.data);
                            end
                            for (int i = 0; i < 4; i++) begin
                                if (mem_sel_o[i]) rsp_mem[mem_addr_o + i] = mem_data_o[8*i +: 8];
                            end
                        end else begin
                            check_eq("load_after_drain", exp_wr.size(), 0);
                            check_eq("load_sel", 32'(mem_sel_o), 32'hf);
                            check_eq("load_word_addr", 32'(mem_addr_o[1:0]), 0);
                            mem_data_i = {rd_rsp(mem_addr_o + 3), rd_rsp(mem_addr_o + 2),
                                          rd_rsp(mem_addr_o + 1), rd_rsp(mem_addr_o)};
                        end
                    end else begin
                        wait_cnt--;
                    end
                end
            end
        end
    end

    // One bubble cycle with no memory op
    task automatic bubble();
        @(negedge clk);
        op_i = OpNone;
        #1;
    endtask

    // Present one instruction and hold it until the stage stops stalling
    task automatic issue(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] d,
                         output int stalls, output logic [31:0] got);
        logic [RW-1:0] wd;
        logic          wr;
        logic [31:0]   alu, val;
        int            sz;
        bit            mis, ld, st;
        wr_t           w;
        wd  = RW'($urandom);
        wr  = 1'($urandom);
        alu = $urandom;
        sz  = op_size(op);
        ld  = (op >= OpLb) && (op <= OpLw);
        st  = (op >= OpSb) && (op <= OpSw);
        mis = (sz > 1) && ((addr & 32'(sz - 1)) != 0);
        @(negedge clk);
        op_i = op; mem_addr_i = addr; reg2_i = d; wd_i = wd; wreg_i = wr; wdata_i = alu;
        #1;
        check_eq("misalign", 32'(misalign_o), 32'(mis));
        check_eq("wreg", 32'(wreg_o), 32'(wr & !mis));
        check_eq("wd", 32'(wd_o), 32'(wd));
        stalls = 0;
        while (stallreq && stalls < 300) begin
            if (hold_ack && stalls == release_at) hold_ack = 1'b0;
            @(negedge clk);
            #1;
            stalls++;
        end
        check_eq("stall_bounded", 32'(stalls < 300), 32'd1);
        got = wdata_o;
        if (mis || !(ld || st)) check_eq("no_stall", stalls, 0);
        if (ld && !mis) begin
            val = '0;
            for (int i = 0; i < sz; i++) val = val | (32'(rd_ref(addr + i)) << (8 * i));
            if (op == OpLb && val[7])  val = val | 32'hffff_ff00;
            if (op == OpLh && val[15]) val = val | 32'hffff_0000;
            check_eq("load_data", wdata_o, val);
        end else begin
            check_eq("wdata_pass", wdata_o, alu);
        end
        if (st && !mis) begin
            w.addr = addr & ~32'd3;
            w.sel  = '0;
            for (int i = 0; i < sz; i++) w.sel[int'(addr[1:0]) + i] = 1'b1;
            w.data = (sz == 1) ? {4{d[7:0]}} : (sz == 2) ? {2{d[15:0]}} : d;
            exp_wr.push_back(w);
            for (int i = 0; i < sz; i++) ref_mem[addr + i] = d[8*i +: 8];
        end
    endtask

    // Wait for all expected writes to reach memory and the port to go quiet
    task automatic drain_wait();
        int n = 0;
        bubble();
        while ((exp_wr.size() != 0 || mem_req_o) && n < 200) begin
            bubble();
            n++;
        end
        check_eq("drained", exp_wr.size(), 0);
    endtask

    task automatic check_all_zero(input string tag);
        check_eq(tag, 32'(|{wd_o, wreg_o, wdata_o, misalign_o, stallreq, mem_req_o, mem_we_o,
                            mem_addr_o, mem_sel_o, mem_data_o}), 32'd0);
    endtask

    initial begin
        int          st;
        logic [31:0] got;
        int          n;
        bit          saw_req;

        rst = 1'b1; op_i = OpLw; mem_addr_i = 32'h100; reg2_i = '1;
        wd_i = '1; wreg_i = 1'b1; wdata_i = '1;
        repeat (2) @(negedge clk);
        #1;
        check_all_zero("reset_outputs");
        @(negedge clk);
        rst = 1'b0; op_i = OpNone;

        // Stray ack straight after reset does nothing
        force_ack = 1'b1;
        repeat (2) bubble();
        force_ack = 1'b0;
        bubble();
        check_eq("stray_ack_no_req", 32'(mem_req_o), 0);

        // SW to empty buffer: no stall, then a held write request
        hold_ack = 1'b1;
        issue(OpSw, 32'h100, 32'hdead_beef, st, got);
        check_eq("sw_no_stall", st, 0);
        n = 0;
        bubble();
        while (!mem_req_o && n < 4) begin bubble(); n++; end
        check_eq("sw_req", 32'(mem_req_o), 1);
        check_eq("sw_we", 32'(mem_we_o), 1);
        check_eq("sw_addr", mem_addr_o, 32'h100);
        check_eq("sw_sel", 32'(mem_sel_o), 32'hf);
        check_eq("sw_data", mem_data_o, 32'hdead_beef);
        hold_ack = 1'b0;
        drain_wait();

        // SB then signed/unsigned byte loads of the same byte
        issue(OpSb, 32'h203, 32'h0000_00a5, st, got);
        issue(OpLb, 32'h203, 32'h0, st, got);
        check_eq("lb_const", got, 32'hffff_ffa5);
        issue(OpLbu, 32'h203, 32'h0, st, got);
        check_eq("lbu_const", got, 32'h0000_00a5);
        issue(OpLw, 32'h300, 32'h0, st, got);
        check_eq("load_latency", st, 2);

        // Fill the buffer with acks held; fifth store stalls until memory responds
        hold_ack = 1'b1;
        for (int i = 0; i < 4; i++) begin
            issue(OpSw, 32'h400 + 32'(4 * i), $urandom, st, got);
            check_eq("fill_no_stall", st, 0);
        end
        release_at = 6;
        issue(OpSw, 32'h410, 32'h5555_aaaa, st, got);
        check_eq("full_stalls", 32'(st > 6), 32'd1);
        release_at = 1000000;
        hold_ack   = 1'b0;
        drain_wait();

        // Misaligned accesses: flagged, no stall, no request
        issue(OpLh, 32'h101, 32'h0, st, got);
        saw_req = 1'b0;
        for (int i = 0; i < 3; i++) begin bubble(); saw_req |= mem_req_o; end
        check_eq("lh_mis_no_req", 32'(saw_req), 0);
        issue(OpSw, 32'h102, 32'h1234_5678, st, got);
        saw_req = 1'b0;
        for (int i = 0; i < 3; i++) begin bubble(); saw_req |= mem_req_o; end
        check_eq("sw_mis_no_req", 32'(saw_req), 0);

        // Two buffered stores drain before the load is requested
        max_wait = 2;
        issue(OpSw, 32'h300, 32'h0bad_f00d, st, got);
        issue(OpSh, 32'h302, 32'h0000_c0de, st, got);
        issue(OpLw, 32'h300, 32'h0, st, got);
        check_eq("lw_after_stores", got, 32'hc0de_f00d);
        drain_wait();

        // Reset in the middle of a drain discards buffered stores
        ref_snap = ref_mem;
        hold_ack = 1'b1;
        for (int i = 0; i < 3; i++) issue(OpSb, 32'h500 + 32'(i), $urandom, st, got);
        repeat (2) bubble();
        check_eq("drain_active", 32'(mem_req_o), 1);
        @(negedge clk);
        rst = 1'b1; op_i = OpLw; mem_addr_i = 32'h500; wreg_i = 1'b1; wd_i = '1; wdata_i = '1;
        @(negedge clk);
        #1;
        check_all_zero("mid_reset_outputs");
        @(negedge clk);
        rst = 1'b0; op_i = OpNone;
        exp_wr.delete();
        ref_mem  = ref_snap;
        hold_ack = 1'b0;
        force_ack = 1'b1;
        repeat (2) bubble();
        force_ack = 1'b0;
        bubble();
        check_eq("post_reset_no_req", 32'(mem_req_o), 0);
        issue(OpLw, 32'h500, 32'h0, st, got);
        check_eq("post_reset_latency", st, 2);

        // Random instruction stream
        max_wait = 3;
        for (int k = 0; k < 300; k++) begin
            issue(4'($urandom_range(0, 10)), 32'h100 + 32'($urandom_range(0, 31)), $urandom,
                  st, got);
        end
        drain_wait();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1);
    end

endmodule
